// File: rtl/tone_detector_pkg.sv
// rtl/tone_detector_pkg.sv - shared types and constants for the tone detector
package tone_detector_pkg;

  localparam int TONE_N = 4;

  typedef logic [1:0] tone_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

endpackage

// File: rtl/tone_period_meter.sv
// rtl/tone_period_meter.sv - input sync, optional glitch filter (TONE_DETECTOR_GLITCH_FILTER_EN), edge detect, period counter
module tone_period_meter #(
  parameter int TIMEOUT = 65535,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  output logic             rise,
  output logic [CNT_W-1:0] period,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic             sync1;
  logic             sync2;
  logic             lvl;
  logic             lvl_next;
  logic             rise_q;
  logic [CNT_W-1:0] cnt;

`ifdef TONE_DETECTOR_GLITCH_FILTER_EN
  logic [1:0] hist;

  // Level flips only once the current and two previous samples agree.
  always_comb begin
    lvl_next = lvl;
    if (sync2 && (&hist))
      lvl_next = 1'b1;
    else if (!sync2 && !(|hist))
      lvl_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      hist <= '0;
    else
      hist <= {hist[0], sync2};
  end
`else
  assign lvl_next = sync2;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      lvl    <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync1  <= in;
      sync2  <= sync1;
      lvl    <= lvl_next;
      rise_q <= lvl_next & ~lvl;
    end
  end

  // Count restarts at 1 on a rise so it equals the rise-to-rise distance at the next rise.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (rise_q)
      cnt <= CNT_W'(1);
    else if (cnt != TIMEOUT_C)
      cnt <= cnt + 1'b1;
  end

  assign rise    = rise_q;
  assign period  = cnt;
  assign timeout = (cnt == TIMEOUT_C);

endmodule

// File: rtl/tone_detector.sv
// rtl/tone_detector.sv - classifies a square-wave period into one of four tones; glitch filter via TONE_DETECTOR_GLITCH_FILTER_EN
module tone_detector
  import tone_detector_pkg::*;
#(
  parameter int P0      = 27273,
  parameter int P1      = 24291,
  parameter int P2      = 22945,
  parameter int P3      = 20443,
  parameter int TOL     = 64,
  parameter int STABLE  = 4,
  parameter int TIMEOUT = 65535,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  output tone_idx_t        tone_id,
  output logic             tone_valid,
  output logic [CNT_W-1:0] period,
  output logic             period_stb
);

  localparam int MW = $clog2(STABLE + 1);
  localparam logic [MW-1:0]    STABLE_C = MW'(STABLE);
  localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] PK [TONE_N] = '{CNT_W'(P0), CNT_W'(P1), CNT_W'(P2), CNT_W'(P3)};

  logic             rise;
  logic             timeout;
  logic [CNT_W-1:0] meas;

  tone_period_meter #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_meter (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in),
    .rise   (rise),
    .period (meas),
    .timeout(timeout)
  );

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic      hit;
  tone_idx_t hit_k;

  // Walk from the highest index down so the lowest matching tone wins.
  always_comb begin
    hit   = 1'b0;
    hit_k = '0;
    for (int k = TONE_N - 1; k >= 0; k--) begin
      if (abs_diff(meas, PK[k]) <= TOL_C) begin
        hit   = 1'b1;
        hit_k = tone_idx_t'(k);
      end
    end
  end

  state_t           state, state_n;
  tone_idx_t        cand, cand_n;
  logic             cand_v, cand_v_n;
  logic [MW-1:0]    mcnt, mcnt_n;
  tone_idx_t        tone_id_n;
  logic [CNT_W-1:0] period_n;
  logic             stb_n;

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    cand_v_n  = cand_v;
    mcnt_n    = mcnt;
    tone_id_n = tone_id;
    period_n  = period;
    stb_n     = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n  = MEASURE;
          mcnt_n   = '0;
          cand_v_n = 1'b0;
          cand_n   = '0;
        end
      end
      default: begin
        if (rise) begin
          stb_n    = 1'b1;
          period_n = meas;
          if (hit) begin
            if (cand_v && (cand == hit_k)) begin
              mcnt_n = (mcnt >= STABLE_C) ? STABLE_C : MW'(mcnt + 1'b1);
            end else begin
              cand_n   = hit_k;
              cand_v_n = 1'b1;
              mcnt_n   = MW'(1);
            end
          end else begin
            mcnt_n   = '0;
            cand_v_n = 1'b0;
            cand_n   = '0;
          end
          if (hit && (mcnt_n == STABLE_C)) begin
            state_n   = LOCKED;
            tone_id_n = cand_n;
          end else begin
            state_n = MEASURE;
          end
        end else if (timeout) begin
          // Rise takes priority; a lone timeout drops everything back to unarmed.
          state_n  = IDLE;
          period_n = '0;
          mcnt_n   = '0;
          cand_v_n = 1'b0;
          cand_n   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cand       <= '0;
      cand_v     <= 1'b0;
      mcnt       <= '0;
      tone_id    <= '0;
      tone_valid <= 1'b0;
      period     <= '0;
      period_stb <= 1'b0;
    end else begin
      state      <= state_n;
      cand       <= cand_n;
      cand_v     <= cand_v_n;
      mcnt       <= mcnt_n;
      tone_id    <= tone_id_n;
      tone_valid <= (state_n == LOCKED);
      period     <= period_n;
      period_stb <= stb_n;
    end
  end

endmodule
